ct_ifu_btb_tag_ctrl: RTL
========================

Name: ct_ifu_btb_tag_ctrl

Overview:
Access controller that sits directly upstream of the BTB tag array.
- Arbitrates IF-stage tag lookups against branch-resolution tag updates, and runs a full-array invalidate sweep.
- Drives the array's index, active-low chip enable, active-low per-way write enables, data and clock enable.
- Buffers updates in a small FIFO so that lookups are normally never stalled.

Parameters:
- UPD_DEPTH, 2, number of update FIFO entries (power of two, minimum 2).
- STARVE_MAX, 4, cycles an update may wait behind lookups before it is forced through.
- SWEEP_NUM, 512, number of array indices walked by an invalidate sweep.

Ports:
- forever_cpuclk  in  1  clock; the single clock of the block.
- cpurst  in  1  reset, synchronous, active-high.
- ifctrl_btb_rd_vld  in  1  lookup request.
- ifctrl_btb_rd_index  in  10  lookup index.
- btb_rd_stall  out  1  lookup refused this cycle; requester holds its request.
- btb_tag_rd_vld  out  1  array dout valid; the cycle after a granted lookup.
- bju_btb_upd_vld  in  1  update request.
- bju_btb_upd_index  in  10  update index.
- bju_btb_upd_way  in  2  way to write (0..3).
- bju_btb_upd_tag  in  11  tag value.
- btb_upd_full  out  1  FIFO full; an update offered while full is dropped.
- ifctrl_btb_inv  in  1  start invalidate sweep (pulse).
- btb_inv_busy  out  1  sweep in progress.
- btb_index  out  10  to array A.
- btb_tag_cen_b  out  1  to array CEN, low = access.
- btb_tag_wen  out  4  to array, low = write way n.
- btb_tag_din  out  22  to array D.
- btb_tag_clk_en  out  1  array gated-clock local enable.

Behaviour:
- Interface decision: one clock, forever_cpuclk; cpurst is synchronous, active-high.
- Reset values:
  - btb_tag_cen_b=1, btb_tag_wen=4'hF, btb_index=0, btb_tag_din=0, btb_tag_clk_en=0.
  - btb_rd_stall=0, btb_tag_rd_vld=0, btb_upd_full=0, btb_inv_busy=0.
  - FIFO empty; starve counter=0; FSM in IDLE.
- Reset asserted mid-sweep or with the FIFO non-empty aborts everything and discards all pending updates.
- Array outputs are combinational from this cycle's grant. Exactly one grant per cycle, in this priority order:
  - SWEEP: any cycle in FSM state SWEEP.
  - FORCED WRITE: starve counter == STARVE_MAX.
  - READ: ifctrl_btb_rd_vld asserted.
  - WRITE: FIFO non-empty.
  - NONE.
- READ grant:
  - cen_b=0, wen=4'hF, index=rd_index, clk_en=1.
  - btb_tag_rd_vld=1 on the next cycle.
- WRITE or FORCED WRITE grant (FIFO head):
  - cen_b=0, index=upd_index, din={tag,tag}.
  - wen has only bit[way] low.
  - clk_en=1; pop the head.
- SWEEP grant: cen_b=0, wen=4'h0, din=0, index=sweep counter, clk_en=1.
- NONE: cen_b=1, wen=4'hF, clk_en=0. btb_index and btb_tag_din hold their previous values to avoid toggling.
- btb_rd_stall = rd_vld && grant != READ. Stall occurs during SWEEP or FORCED WRITE only.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the grant is READ.
  - Clears on any WRITE or FORCED WRITE grant, or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- FIFO:
  - btb_upd_full is registered and equals (count == UPD_DEPTH).
  - Push happens when upd_vld && !full.
  - Push and pop in the same cycle with the FIFO full is allowed; full stays 1 and count is unchanged.
  - Push and pop in the same cycle with the FIFO empty is not allowed: a newly pushed entry becomes visible the next cycle.
  - Pointers wrap modulo UPD_DEPTH.
- FSM, states IDLE, DRAIN, SWEEP:
  - IDLE -> DRAIN on ifctrl_btb_inv; btb_inv_busy=1 from the next cycle.
  - In DRAIN, updates already in the FIFO drain via normal arbitration. New pushes are dropped, and full is forced to 1 while busy.
  - DRAIN -> SWEEP when the FIFO is empty.
  - SWEEP writes index 0..SWEEP_NUM-1, one per cycle. After the write to index SWEEP_NUM-1 -> IDLE, and busy drops the following cycle.
  - ifctrl_btb_inv while busy is ignored.
- Index bit 9 passes through unchanged; the sweep counter drives bit 9 = 0.

Test Plan:
1. Reset, then an idle cycle: cen_b=1, wen=F, clk_en=0, all status outputs 0.
2. Read at index 0x05A with no updates: the same cycle shows cen_b=0, wen=F, index=0x05A. The next cycle shows btb_tag_rd_vld=1.
3. Update way 2, index 0x011, tag 0x3A5 while reads are idle:
   - The following cycle shows wen=4'b1011, din=0x1D2BA5 ({0x3A5,0x3A5}), index=0x011.
   - FIFO returns to empty.
4. One update, then continuous reads for 10 cycles:
   - 4 reads are granted; the 5th read cycle has btb_rd_stall=1 and a forced write.
   - Reads resume the next cycle; starve counter reads 0.
5. Three updates on back-to-back cycles while reads block draining:
   - btb_upd_full=1 after the 2nd push; the 3rd update is dropped.
   - Exactly 2 writes are eventually observed.
6. ifctrl_btb_inv pulse with 1 update queued:
   - The update drains first, then 512 sweep writes with wen=0, din=0, index 0..511 in order.
   - Concurrent reads are stalled throughout the sweep.
   - btb_inv_busy falls the cycle after index 511.
   - Reset asserted at sweep index 100 returns all outputs to reset values the next cycle.

Source files
------------

// File: rtl/ct_ifu_btb_tag_ctrl_if.sv
// Bundle of the signals the BTB tag access controller shares with its
// requesters (IF lookup, BJU update, invalidate) and with the tag array.
// master = the surrounding pipeline / array side, slave = the controller.
interface ct_ifu_btb_tag_ctrl_if;
  // IF-stage lookup
  logic        ifctrl_btb_rd_vld;
  logic [9:0]  ifctrl_btb_rd_index;
  logic        btb_rd_stall;
  logic        btb_tag_rd_vld;
  // branch-resolution update
  logic        bju_btb_upd_vld;
  logic [9:0]  bju_btb_upd_index;
  logic [1:0]  bju_btb_upd_way;
  logic [10:0] bju_btb_upd_tag;
  logic        btb_upd_full;
  // invalidate sweep
  logic        ifctrl_btb_inv;
  logic        btb_inv_busy;
  // tag array pins
  logic [9:0]  btb_index;
  logic        btb_tag_cen_b;
  logic [3:0]  btb_tag_wen;
  logic [21:0] btb_tag_din;
  logic        btb_tag_clk_en;

  modport master (
    output ifctrl_btb_rd_vld, ifctrl_btb_rd_index,
    output bju_btb_upd_vld, bju_btb_upd_index, bju_btb_upd_way, bju_btb_upd_tag,
    output ifctrl_btb_inv,
    input  btb_rd_stall, btb_tag_rd_vld, btb_upd_full, btb_inv_busy,
    input  btb_index, btb_tag_cen_b, btb_tag_wen, btb_tag_din, btb_tag_clk_en
  );

  modport slave (
    input  ifctrl_btb_rd_vld, ifctrl_btb_rd_index,
    input  bju_btb_upd_vld, bju_btb_upd_index, bju_btb_upd_way, bju_btb_upd_tag,
    input  ifctrl_btb_inv,
    output btb_rd_stall, btb_tag_rd_vld, btb_upd_full, btb_inv_busy,
    output btb_index, btb_tag_cen_b, btb_tag_wen, btb_tag_din, btb_tag_clk_en
  );
endinterface

// File: rtl/ct_ifu_btb_tag_ctrl.sv
// BTB tag array access controller.
// One array access per cycle, chosen with priority sweep > starved update >
// lookup > queued update. Updates wait in a small FIFO so lookups normally
// proceed unhindered; an update that has waited STARVE_MAX lookup cycles is
// forced through. An invalidate request first drains the FIFO, then writes
// zero to every way of indices 0..SWEEP_NUM-1.
module ct_ifu_btb_tag_ctrl #(
  parameter int UPD_DEPTH  = 2,
  parameter int STARVE_MAX = 4,
  parameter int SWEEP_NUM  = 512
) (
  input logic                  forever_cpuclk,
  input logic                  cpurst,
  ct_ifu_btb_tag_ctrl_if.slave bus
);

  localparam int PW  = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int SW  = (SWEEP_NUM > 1) ? $clog2(SWEEP_NUM) : 1;
  localparam int STW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0]  DEPTH_C      = CW'(UPD_DEPTH);
  localparam logic [STW-1:0] STARVE_MAX_C = STW'(STARVE_MAX);
  localparam logic [SW-1:0]  SWEEP_LAST_C = SW'(SWEEP_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    GNT_NONE  = 3'd0,
    GNT_READ  = 3'd1,
    GNT_WRITE = 3'd2,
    GNT_FORCE = 3'd3,
    GNT_SWEEP = 3'd4
  } grant_t;

  typedef struct packed {
    logic [9:0]  index;
    logic [1:0]  way;
    logic [10:0] tag;
  } upd_t;

  // state
  state_t          state_q, state_d;
  logic [SW-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic            busy_q, busy_d;
  upd_t            fifo_mem_q [UPD_DEPTH];
  upd_t            fifo_mem_d [UPD_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic [STW-1:0]  starve_q, starve_d;
  logic [9:0]      index_q, index_d;
  logic [21:0]     din_q, din_d;
  logic            rd_vld_q, rd_vld_d;

  // combinational helpers
  grant_t          grant;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  upd_t            head;
  upd_t            new_entry;
  logic [9:0]      sweep_index;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_C);
  assign head        = fifo_mem_q[rd_ptr_q];
  assign new_entry   = '{index: bus.bju_btb_upd_index,
                         way:   bus.bju_btb_upd_way,
                         tag:   bus.bju_btb_upd_tag};
  assign sweep_index = {1'b0, 9'(sweep_cnt_q)};

  // Pick the single array access for this cycle; nothing is granted while in reset
  always_comb begin
    grant = GNT_NONE;
    if (!cpurst) begin
      if (state_q == ST_SWEEP) begin
        grant = GNT_SWEEP;
      end else if ((starve_q == STARVE_MAX_C) && !fifo_empty) begin
        grant = GNT_FORCE;
      end else if (bus.ifctrl_btb_rd_vld) begin
        grant = GNT_READ;
      end else if (!fifo_empty) begin
        grant = GNT_WRITE;
      end
    end
  end

  assign pop  = (grant == GNT_WRITE) || (grant == GNT_FORCE);
  // A full FIFO still accepts an update in a cycle that frees the head slot
  assign push = bus.bju_btb_upd_vld && !cpurst && !busy_q && (!fifo_full || pop);

  // Drive the array pins from the grant; address and data park on their last value when idle
  always_comb begin
    bus.btb_tag_cen_b  = 1'b1;
    bus.btb_tag_wen    = 4'hF;
    bus.btb_tag_clk_en = 1'b0;
    bus.btb_index      = index_q;
    bus.btb_tag_din    = din_q;
    case (grant)
      GNT_READ: begin
        bus.btb_tag_cen_b  = 1'b0;
        bus.btb_tag_clk_en = 1'b1;
        bus.btb_index      = bus.ifctrl_btb_rd_index;
      end
      GNT_WRITE, GNT_FORCE: begin
        bus.btb_tag_cen_b  = 1'b0;
        bus.btb_tag_clk_en = 1'b1;
        bus.btb_index      = head.index;
        bus.btb_tag_wen    = ~(4'b0001 << head.way);
        bus.btb_tag_din    = {head.tag, head.tag};
      end
      GNT_SWEEP: begin
        bus.btb_tag_cen_b  = 1'b0;
        bus.btb_tag_clk_en = 1'b1;
        bus.btb_index      = sweep_index;
        bus.btb_tag_wen    = 4'h0;
        bus.btb_tag_din    = '0;
      end
      default: ;
    endcase
  end

  assign bus.btb_rd_stall   = bus.ifctrl_btb_rd_vld && !cpurst && (grant != GNT_READ);
  assign bus.btb_tag_rd_vld = rd_vld_q;
  assign bus.btb_upd_full   = full_q;
  assign bus.btb_inv_busy   = busy_q;

  // Update FIFO bookkeeping: storage write, pointer advance and occupancy
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = new_entry;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Starvation counter counts lookups that overtook a waiting update
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if ((grant == GNT_READ) && (starve_q != STARVE_MAX_C)) begin
      starve_d = starve_q + STW'(1);
    end
  end

  // Invalidate sequencing: drain queued updates, then walk the array
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ifctrl_btb_inv) begin
          state_d     = ST_DRAIN;
          sweep_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (sweep_cnt_q == SWEEP_LAST_C) begin
          state_d     = ST_IDLE;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + SW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sweep_cnt_d = '0;
      end
    endcase
  end

  // Next values of the registered status outputs and parked array pins
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    full_d   = (count_d == DEPTH_C) || busy_d;
    rd_vld_d = (grant == GNT_READ);
    index_d  = bus.btb_index;
    din_d    = bus.btb_tag_din;
  end

  // All state registers; reset abandons any sweep and discards queued updates
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= ST_IDLE;
      sweep_cnt_q <= '0;
      busy_q      <= 1'b0;
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      starve_q    <= '0;
      index_q     <= '0;
      din_q       <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      busy_q      <= busy_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      starve_q    <= starve_d;
      index_q     <= index_d;
      din_q       <= din_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

endmodule
